spatz_scoreboard: RTL

- Hazard scoreboard between spatz_controller issue and the execution units (VFU, VLSU, VSLD).
- Tracks, per vector register, whether an in-flight instruction will still write it, and which unit owns that write.
- Tracks per-unit outstanding-instruction counts.
- Gates issue on RAW/WAW hazards and unit capacity; clears state on unit retire.

---
 rtl/spatz_scoreboard_pkg.sv | 34 +++
 rtl/spatz_scoreboard_if.sv | 22 ++
 rtl/spatz_sb_counter.sv | 39 +++
 rtl/spatz_scoreboard.sv | 113 +++++++++++
 4 files changed

// File: rtl/spatz_scoreboard_pkg.sv
// Shared types and sizing for the Spatz issue scoreboard.
// Unit ids, vreg ids, counter width and the packed issue request bundle.
package spatz_scoreboard_pkg;

  localparam int unsigned NrVregs        = 32;
  localparam int unsigned NrUnits        = 3;
  localparam int unsigned MaxOutstanding = 4;

  localparam int unsigned VregIdWidth = $clog2(NrVregs);
  localparam int unsigned UnitIdWidth = $clog2(NrUnits);
  localparam int unsigned CntWidth    = $clog2(MaxOutstanding + 1);

  typedef logic [VregIdWidth-1:0] vreg_id_t;
  typedef logic [UnitIdWidth-1:0] unit_id_t;
  typedef logic [CntWidth-1:0]    cnt_t;

  typedef enum logic [UnitIdWidth-1:0] {
    UNIT_VFU  = 2'd0,
    UNIT_VLSU = 2'd1,
    UNIT_VSLD = 2'd2
  } unit_id_e;

  // unit is a raw id rather than the enum so out-of-range ids stay representable
  typedef struct packed {
    unit_id_t unit;
    vreg_id_t vd;
    logic     use_vd;
    vreg_id_t vs1;
    logic     use_vs1;
    vreg_id_t vs2;
    logic     use_vs2;
  } sb_issue_req_t;

endpackage

// File: rtl/spatz_scoreboard_if.sv
// Issue handshake and per-unit retire bundle between the controller/units and the scoreboard.
interface spatz_scoreboard_if;
  import spatz_scoreboard_pkg::*;

  logic                        issue_valid;
  logic                        issue_ready;
  sb_issue_req_t               issue_req;
  logic     [NrUnits-1:0]      retire_valid;
  vreg_id_t [NrUnits-1:0]      retire_vd;
  logic     [NrUnits-1:0]      retire_use_vd;

  modport master (
    output issue_valid, issue_req, retire_valid, retire_vd, retire_use_vd,
    input  issue_ready
  );

  modport slave (
    input  issue_valid, issue_req, retire_valid, retire_vd, retire_use_vd,
    output issue_ready
  );

endinterface

// File: rtl/spatz_sb_counter.sv
// Up/down outstanding-instruction counter saturating at 0 and MaxOutstanding.
module spatz_sb_counter
  import spatz_scoreboard_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc,
  input  logic dec,
  output cnt_t count,
  output logic full,
  output logic empty
);

  localparam cnt_t CntMax = cnt_t'(MaxOutstanding);

  cnt_t count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && !dec && count_q != CntMax) begin
      count_d = count_q + cnt_t'(1);
    end else if (dec && !inc && count_q != '0) begin
      count_d = count_q - cnt_t'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign full  = (count_q == CntMax);
  assign empty = (count_q == '0);

endmodule

// File: rtl/spatz_scoreboard.sv
// Per-vreg pending-write scoreboard gating issue on RAW/WAW hazards and unit capacity.
// Same-cycle retires bypass into the hazard check so dependents issue without a bubble.
module spatz_scoreboard
  import spatz_scoreboard_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_i,
  spatz_scoreboard_if.slave       sb,
  output logic [NrVregs-1:0]      busy_o,
  output cnt_t [NrUnits-1:0]      unit_cnt_o,
  output logic                    err_o
);

  localparam unit_id_t LastUnit = unit_id_t'(NrUnits - 1);

  sb_issue_req_t          req;
  logic [NrVregs-1:0]     busy_q, busy_d, clr, eff_busy;
  unit_id_t [NrVregs-1:0] owner_q, owner_d;
  logic [NrUnits-1:0]     fire_u, cnt_full, cnt_empty;
  logic                   unit_ok, haz, full, fire, err_q, err_d;

  assign req     = sb.issue_req;
  assign unit_ok = (req.unit <= LastUnit);

  always_comb begin
    clr = '0;
    for (int u = 0; u < NrUnits; u++) begin
      if (sb.retire_valid[u] && sb.retire_use_vd[u]) clr[sb.retire_vd[u]] = 1'b1;
    end
  end

  assign eff_busy = busy_q & ~clr;

  // A pending write owned by the issuing unit is safe: units complete in order
  always_comb begin
    haz = 1'b0;
    if (req.use_vs1 && eff_busy[req.vs1] && owner_q[req.vs1] != req.unit) haz = 1'b1;
    if (req.use_vs2 && eff_busy[req.vs2] && owner_q[req.vs2] != req.unit) haz = 1'b1;
    if (req.use_vd  && eff_busy[req.vd]  && owner_q[req.vd]  != req.unit) haz = 1'b1;
  end

  always_comb begin
    full = 1'b0;
    for (int u = 0; u < NrUnits; u++) begin
      if (req.unit == unit_id_t'(u) && cnt_full[u] && !sb.retire_valid[u]) full = 1'b1;
    end
  end

  assign sb.issue_ready = !rst_i && !haz && !full && unit_ok;
  assign fire           = sb.issue_valid && sb.issue_ready;

  // Retire clears first so a same-cycle issue to that vreg wins
  always_comb begin
    busy_d  = busy_q;
    owner_d = owner_q;
    for (int u = 0; u < NrUnits; u++) begin
      if (sb.retire_valid[u] && sb.retire_use_vd[u] &&
          owner_q[sb.retire_vd[u]] == unit_id_t'(u)) begin
        busy_d[sb.retire_vd[u]] = 1'b0;
      end
    end
    if (fire && req.use_vd) begin
      busy_d[req.vd]  = 1'b1;
      owner_d[req.vd] = req.unit;
    end
  end

  always_comb begin
    err_d = err_q;
    if (sb.issue_valid && !unit_ok) err_d = 1'b1;
    for (int u = 0; u < NrUnits; u++) begin
      if (sb.retire_valid[u]) begin
        if (cnt_empty[u]) err_d = 1'b1;
        if (sb.retire_use_vd[u] && (!busy_q[sb.retire_vd[u]] ||
            owner_q[sb.retire_vd[u]] != unit_id_t'(u))) err_d = 1'b1;
        for (int w = u + 1; w < NrUnits; w++) begin
          if (sb.retire_valid[w] && sb.retire_use_vd[u] && sb.retire_use_vd[w] &&
              sb.retire_vd[u] == sb.retire_vd[w]) err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q  <= '0;
      owner_q <= '0;
      err_q   <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      owner_q <= owner_d;
      err_q   <= err_d;
    end
  end

  for (genvar u = 0; u < NrUnits; u++) begin : gen_cnt
    assign fire_u[u] = fire && (req.unit == unit_id_t'(u));

    spatz_sb_counter i_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc   (fire_u[u]),
      .dec   (sb.retire_valid[u]),
      .count (unit_cnt_o[u]),
      .full  (cnt_full[u]),
      .empty (cnt_empty[u])
    );
  end

  assign busy_o = busy_q;
  assign err_o  = err_q;

endmodule
